upc_scan_front: RTL and testbench
=================================

# upc_scan_front

Sequential front end for the checkout datapath: conditions a raw active-low scan button and the raw UPC/mark switches, debounces the press, and produces one registered, stable item record (3-bit UPC + mark bit) with a single-cycle valid pulse per physical press. Sits directly upstream of the combinational UPC marker (discount/sale) and UPC hex display stages, replacing their direct switch connections with held, registered values. Also keeps a saturating item count for the transaction.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a press or release; must be ≥ 2 (board build overrides to 50000 at 50 MHz)
- CNT_W, 4, width of item_count
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- scan_n  in  1  raw scan button (KEY[0]), active-low, asynchronous, bouncy
- upc_in  in  3  raw UPC switches {U,P,C}
- mark_in  in  1  raw mark switch
- upc  out  3  latched UPC of last accepted item; feeds marker/display
- mark  out  1  latched mark of last accepted item
- item_valid  out  1  one-cycle pulse when a new item is latched
- item_count  out  CNT_W  accepted items since reset, saturating
- count_full  out  1  high when item_count = 2^CNT_W−1

## Operation
- scan_n, upc_in, mark_in each pass through a 2-flop synchronizer; synchronized signals are s_press (= ~scan_n synced), s_upc, s_mark.
- Debounce counter cnt, width $clog2(DEBOUNCE_CYCLES)+1.
- FSM states:
  - IDLE: s_press=1 → PRESS_DB, cnt←1; else stay.
  - PRESS_DB: s_press=0 → IDLE; s_press=1 and cnt=DEBOUNCE_CYCLES−1 → HELD, upc←s_upc, mark←s_mark, item_valid←1, item_count increments; else cnt++.
  - HELD: s_press=0 → REL_DB, cnt←1; else stay.
  - REL_DB: s_press=1 → HELD; s_press=0 and cnt=DEBOUNCE_CYCLES−1 → IDLE; else cnt++.
- Exactly one item_valid per accepted press regardless of hold length.
- upc/mark change only on the item_valid edge; switch changes during HELD/REL_DB/IDLE are ignored.
- item_count saturates at 2^CNT_W−1; further accepted presses still pulse item_valid and update upc/mark but do not change item_count.
- count_full is combinational from item_count.

## Timing
- Reset (async assert, sync-safe deassert assumed by top): state IDLE, cnt 0, upc 3'b000, mark 0, item_valid 0, item_count 0, count_full 0; scan synchronizer flops reset to released (1), data synchronizer flops to 0.
- Latency: if scan_n is first sampled low at edge k and held low, item_valid is high for exactly the cycle following edge k+DEBOUNCE_CYCLES+1 (edge k+5 at default).
- upc/mark reflect pin values sampled at edge k+DEBOUNCE_CYCLES−1 and are valid in the same cycle as item_valid.
- A low glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no pulse.
- A new press is not accepted until release is stable for DEBOUNCE_CYCLES samples.
- reset_n asserted mid-debounce or mid-hold: all outputs clear immediately; after deassertion with button still held, a fresh full press debounce is required (FSM starts in IDLE, so held button is accepted once after DEBOUNCE_CYCLES+1 edges).

## Structure
- Package upc_pkg: UPC_W = 3, enum scan_state_t {IDLE, PRESS_DB, HELD, REL_DB}.
- Sub-module sync2 (parameterised width, parameterised reset value), instantiated for scan_n and for {upc_in, mark_in}.
- Top-level wiring: upc/mark drive the existing marker and display instances; item_count may drive HEX1.

## Test plan
- Reset: reset_n=0 for 3 cycles → upc=000, mark=0, item_valid=0, item_count=0, count_full=0.
- Clean press: upc_in=101, mark_in=1, scan_n low from edge k for 10 cycles → single item_valid pulse after edge k+5, upc=101, mark=1, item_count=1.
- Bounce: scan_n low 2 cycles, high 1, low 2, then high → no item_valid, item_count=0.
- Long hold and switch change: hold scan_n low 50 cycles, change upc_in to 010 during hold → one pulse, upc stays at press-time value; release 10 cycles, press again → upc=010, item_count=2.
- Saturation: 16 accepted presses → item_count=15, count_full=1 after the 15th; 16th still pulses item_valid and updates upc.
- Mid-operation reset: assert reset_n during PRESS_DB with cnt=2 → outputs zero immediately, no pulse; deassert with scan_n still low → exactly one pulse DEBOUNCE_CYCLES+1 edges after first post-reset sample, item_count=1.

Source files
------------

// File: rtl/upc_pkg.sv
// Shared types for the scan front end: item field width and the debounce FSM states.
package upc_pkg;

  localparam int UPC_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } scan_state_t;

endpackage

// File: rtl/upc_scan_front_sync2.sv
// Two-flop synchronizer for raw board inputs, with a selectable reset value per instance.
module sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/upc_scan_front.sv
// Scan front end: synchronizes and debounces the scan button, latches one item record
// (UPC + mark) per physical press with a single-cycle valid, and keeps a saturating item count.
module upc_scan_front
  import upc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan_n,
  input  logic [UPC_W-1:0] upc_in,
  input  logic             mark_in,
  output logic [UPC_W-1:0] upc,
  output logic             mark,
  output logic             item_valid,
  output logic [CNT_W-1:0] item_count,
  output logic             count_full,
  output logic [1:0]       state_dbg
);

  localparam int            DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic             s_scan_n;
  logic             s_press;
  logic [UPC_W-1:0] s_upc;
  logic             s_mark;

  // Button idles released (high), so its synchronizer resets to 1 to avoid a phantom press.
  sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (scan_n),
    .q_o     (s_scan_n)
  );

  sync2 #(.W(UPC_W + 1), .RST_VAL('0)) u_sync_data (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     ({upc_in, mark_in}),
    .q_o     ({s_upc, s_mark})
  );

  assign s_press = ~s_scan_n;

  scan_state_t      state_q, state_d;
  logic [DB_W-1:0]  cnt_q, cnt_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  logic             mark_q, mark_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      upc_q   <= '0;
      mark_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      upc_q   <= upc_d;
      mark_q  <= mark_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (s_press) state_d = PRESS_DB;
      PRESS_DB: begin
        if (!s_press)               state_d = IDLE;
        else if (cnt_q == DB_LAST)  state_d = HELD;
      end
      HELD:     if (!s_press) state_d = REL_DB;
      REL_DB: begin
        if (s_press)                state_d = HELD;
        else if (cnt_q == DB_LAST)  state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    accept = 1'b0;
    case (state_q)
      IDLE:     if (s_press) cnt_d = DB_W'(1);
      PRESS_DB: begin
        if (s_press && cnt_q == DB_LAST) accept = 1'b1;
        else if (s_press)                cnt_d  = cnt_q + DB_W'(1);
      end
      HELD:     if (!s_press) cnt_d = DB_W'(1);
      REL_DB:   if (!s_press && cnt_q != DB_LAST) cnt_d = cnt_q + DB_W'(1);
      default:  cnt_d = '0;
    endcase

    // The record is captured only on the accepting edge; switch motion at any other time is ignored.
    upc_d   = accept ? s_upc  : upc_q;
    mark_d  = accept ? s_mark : mark_q;
    valid_d = accept;
    count_d = (accept && count_q != '1) ? count_q + CNT_W'(1) : count_q;
  end

  assign upc        = upc_q;
  assign mark       = mark_q;
  assign item_valid = valid_q;
  assign item_count = count_q;
  assign count_full = &count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_upc_scan_front.sv
// Directed bench for upc_scan_front: stimulus pushes expected item records, a monitor checks them.
module tb_upc_scan_front;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scan_n;
  logic [2:0] upc_in;
  logic       mark_in;
  logic [2:0] upc;
  logic       mark;
  logic       item_valid;
  logic [3:0] item_count;
  logic       count_full;
  logic [1:0] state_dbg;

  upc_scan_front #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scan_n     (scan_n),
    .upc_in     (upc_in),
    .mark_in    (mark_in),
    .upc        (upc),
    .mark       (mark),
    .item_valid (item_valid),
    .item_count (item_count),
    .count_full (count_full),
    .state_dbg  (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state: expected {upc, mark, count} and the cycle the pulse must appear in
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [2:0] mon_upc  = 3'b000;
  logic       mon_mark = 1'b0;
  logic [3:0] mon_cnt  = 4'd0;
  logic [3:0] model_cnt = 4'd0;
  logic [7:0] e;
  int         ec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle either a pulse matching the queue head or steady held outputs
  always @(negedge clk) begin
    if (item_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_item_valid", {31'd0, item_valid}, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("item_upc",        {29'd0, upc},        {29'd0, e[7:5]});
        check("item_mark",       {31'd0, mark},       {31'd0, e[4]});
        check("item_count",      {28'd0, item_count}, {28'd0, e[3:0]});
        check("item_count_full", {31'd0, count_full}, {31'd0, (e[3:0] == 4'd15)});
        check("item_latency",    cyc,                 ec);
        mon_upc  = e[7:5];
        mon_mark = e[4];
        mon_cnt  = e[3:0];
      end
    end else begin
      check("hold_upc",        {29'd0, upc},        {29'd0, mon_upc});
      check("hold_mark",       {31'd0, mark},       {31'd0, mon_mark});
      check("hold_count",      {28'd0, item_count}, {28'd0, mon_cnt});
      check("hold_count_full", {31'd0, count_full}, {31'd0, (mon_cnt == 4'd15)});
    end
  end

  // Driver tasks
  task automatic expect_item(input logic [2:0] u, input logic m);
    if (model_cnt != 4'd15) model_cnt++;
    exp_q.push_back({u, m, model_cnt});
    exp_cyc_q.push_back(cyc + 6);
  endtask

  task automatic press(input logic [2:0] u, input logic m, input int hold, input int rel);
    @(negedge clk);
    upc_in  = u;
    mark_in = m;
    scan_n  = 1'b0;
    expect_item(u, m);
    repeat (hold) @(negedge clk);
    scan_n = 1'b1;
    repeat (rel) @(negedge clk);
  endtask

  initial begin
    scan_n  = 1'b1;
    upc_in  = 3'b000;
    mark_in = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;

    // Reset state, with switches active to show they are not latched
    upc_in  = 3'b111;
    mark_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_upc",   {29'd0, upc},        32'd0);
    check("rst_mark",  {31'd0, mark},       32'd0);
    check("rst_valid", {31'd0, item_valid}, 32'd0);
    check("rst_count", {28'd0, item_count}, 32'd0);
    check("rst_full",  {31'd0, count_full}, 32'd0);
    check("rst_state", {30'd0, state_dbg},  32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press
    press(3'b101, 1'b1, 10, 10);

    // Bounce shorter than the debounce window
    @(negedge clk);
    upc_in = 3'b001;
    scan_n = 1'b0;
    repeat (2) @(negedge clk);
    scan_n = 1'b1;
    @(negedge clk);
    scan_n = 1'b0;
    repeat (2) @(negedge clk);
    scan_n = 1'b1;
    repeat (10) @(negedge clk);
    check("bounce_count", {28'd0, item_count}, 32'd1);

    // Long hold with switches changing mid-hold
    @(negedge clk);
    upc_in  = 3'b011;
    mark_in = 1'b0;
    scan_n  = 1'b0;
    expect_item(3'b011, 1'b0);
    repeat (20) @(negedge clk);
    check("hold_state", {30'd0, state_dbg}, 32'd2);
    upc_in  = 3'b010;
    mark_in = 1'b1;
    repeat (30) @(negedge clk);
    scan_n = 1'b1;
    repeat (10) @(negedge clk);
    press(3'b010, 1'b1, 8, 8);
    check("second_press_upc", {29'd0, upc}, 32'd2);

    // Saturation: keep pressing well past 15 accepted items
    for (int i = 0; i < 14; i++) begin
      press(3'(i) ^ 3'b110, i[0], 8, 8);
    end
    check("sat_count", {28'd0, item_count}, 32'd15);
    check("sat_full",  {31'd0, count_full}, 32'd1);

    // Reset while debouncing a press (cnt = 2), then keep the button held through release of reset
    @(negedge clk);
    upc_in  = 3'b110;
    mark_in = 1'b1;
    scan_n  = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_state_press_db", {30'd0, state_dbg}, 32'd1);
    reset_n   = 1'b0;
    mon_upc   = 3'b000;
    mon_mark  = 1'b0;
    mon_cnt   = 4'd0;
    model_cnt = 4'd0;
    #1;
    check("mid_rst_upc",   {29'd0, upc},        32'd0);
    check("mid_rst_mark",  {31'd0, mark},       32'd0);
    check("mid_rst_valid", {31'd0, item_valid}, 32'd0);
    check("mid_rst_count", {28'd0, item_count}, 32'd0);
    check("mid_rst_full",  {31'd0, count_full}, 32'd0);
    check("mid_rst_state", {30'd0, state_dbg},  32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    expect_item(3'b110, 1'b1);

    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_count", {28'd0, item_count}, 32'd1);
    scan_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
